// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between the fetch port and the data port (data wins by default).
// Define MEM_ARBITER_STARVE_GUARD_EN to force a fetch grant after STARVE_LIM consecutive data grants made while fetch waits.
module mem_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int MAX_WAIT   = 15,
    parameter int STARVE_LIM = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          err,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready
);

    typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;

    localparam logic [8:0] LP_MAX_WAIT = 9'(MAX_WAIT);

    if (MAX_WAIT < 1 || MAX_WAIT > 255 || STARVE_LIM < 1) begin : g_param_check
        $error("mem_arbiter: MAX_WAIT must be 1..255 and STARVE_LIM at least 1");
    end

    state_t        r_state, w_state_nxt;
    logic          r_m_en, r_m_we;
    logic [AW-1:0] r_m_addr;
    logic [DW-1:0] r_m_wdata;
    logic [DW-1:0] r_if_rdata, r_d_rdata;
    logic          r_if_ack, r_d_ack, r_err;
    logic [7:0]    r_wait;
    logic [8:0]    w_wait_inc;
    logic          w_grant_if, w_grant_d, w_done_ok, w_timeout, w_force_if;

    assign w_wait_inc = {1'b0, r_wait} + 9'd1;

`ifdef MEM_ARBITER_STARVE_GUARD_EN
    localparam logic [7:0] LP_STARVE_LIM = 8'(STARVE_LIM);
    logic [7:0] r_starve;

    assign w_force_if = if_req && (r_starve >= LP_STARVE_LIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
        end else if (w_grant_if) begin
            r_starve <= '0;
        end else if (w_grant_d) begin
            if (!if_req)
                r_starve <= '0;
            else if (r_starve != 8'hFF)
                r_starve <= r_starve + 8'd1;
        end
    end
`else
    assign w_force_if = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // No grant while an ack is pulsing: the requester still holds its request in that cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_if  = 1'b0;
        w_grant_d   = 1'b0;
        w_done_ok   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!(r_if_ack || r_d_ack)) begin
                    if (d_req && !w_force_if) begin
                        w_grant_d   = 1'b1;
                        w_state_nxt = D_BUSY;
                    end else if (if_req) begin
                        w_grant_if  = 1'b1;
                        w_state_nxt = IF_BUSY;
                    end
                end
            end
            IF_BUSY, D_BUSY: begin
                if (m_ready) begin
                    w_done_ok   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_wait_inc >= LP_MAX_WAIT) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m_en     <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_if_ack   <= 1'b0;
            r_d_ack    <= 1'b0;
            r_err      <= 1'b0;
            r_wait     <= '0;
        end else begin
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
            r_err    <= 1'b0;
            if (w_grant_d) begin
                r_m_en    <= 1'b1;
                r_m_we    <= d_we;
                r_m_addr  <= d_addr;
                r_m_wdata <= d_wdata;
                r_wait    <= '0;
            end else if (w_grant_if) begin
                r_m_en    <= 1'b1;
                r_m_we    <= 1'b0;
                r_m_addr  <= if_addr;
                r_m_wdata <= '0;
                r_wait    <= '0;
            end else if (w_done_ok || w_timeout) begin
                r_m_en <= 1'b0;
                r_m_we <= 1'b0;
                r_err  <= w_timeout;
                if (r_state == IF_BUSY) begin
                    r_if_ack   <= 1'b1;
                    r_if_rdata <= w_done_ok ? m_rdata : '1;
                end else begin
                    r_d_ack <= 1'b1;
                    // Writes never disturb the data read register, even on abort.
                    if (!r_m_we)
                        r_d_rdata <= w_done_ok ? m_rdata : '1;
                end
            end else if (r_state != IDLE && r_wait != 8'hFF) begin
                r_wait <= r_wait + 8'd1;
            end
        end
    end

    assign m_en      = r_m_en;
    assign m_we      = r_m_we;
    assign m_addr    = r_m_addr;
    assign m_wdata   = r_m_wdata;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign if_ack    = r_if_ack;
    assign d_ack     = r_d_ack;
    assign err       = r_err;
    assign stall_if  = if_req & ~r_if_ack;
    assign stall_mem = d_req & ~r_d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with MAX_WAIT = 4 and STARVE_LIM = 3; a small memory model answers after rdy_lat cycles.
// Honours MEM_ARBITER_STARVE_GUARD_EN when choosing the expected grant order.
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] if_rdata, d_rdata;
    logic          if_ack, d_ack, err, stall_if, stall_mem;
    logic          m_en, m_we, m_ready;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    int            rdy_lat;
    logic [DW-1:0] mem_data;
    int            en_cnt = 0;
    logic          ack_both = 1'b0;
    int            errors = 0;
    int            checks = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4), .STARVE_LIM(3)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    // Memory answers in the rdy_lat-th cycle of m_en; rdy_lat = 0 never answers.
    always @(posedge clk) en_cnt <= m_en ? en_cnt + 1 : 0;
    assign m_ready = m_en && (rdy_lat != 0) && (en_cnt == rdy_lat - 1);
    assign m_rdata = mem_data;

    always @(negedge clk) if (if_ack && d_ack) ack_both = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   got_order [5];
        int   exp_order [5];
        int   n_grants;
        logic prev_en;
        logic seen_ack;

        reset = 1'b1;
        if_req = 1'b1; if_addr = 16'h0010;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_data = 16'hA5A5; rdy_lat = 1;
        cyc(2);
        check_eq("rst_ctrl", {m_en, m_we, if_ack, d_ack, err}, 5'b0);
        check_eq("rst_addr", m_addr, 16'h0000);
        check_eq("rst_wdata", m_wdata, 16'h0000);
        check_eq("rst_if_rdata", if_rdata, 16'h0000);
        check_eq("rst_d_rdata", d_rdata, 16'h0000);

        // Fetch only, ready in the first m_en cycle
        reset = 1'b0;
        #1 check_eq("no_early_grant", m_en, 1'b0);
        check_eq("f_stall0", stall_if, 1'b1);
        cyc(1);
        check_eq("f_m_en", m_en, 1'b1);
        check_eq("f_m_addr", m_addr, 16'h0010);
        check_eq("f_m_we", m_we, 1'b0);
        check_eq("f_stall1", stall_if, 1'b1);
        check_eq("f_no_ack_yet", if_ack, 1'b0);
        cyc(1);
        check_eq("f_ack", if_ack, 1'b1);
        check_eq("f_rdata", if_rdata, 16'hA5A5);
        check_eq("f_err", err, 1'b0);
        check_eq("f_m_en_off", m_en, 1'b0);
        check_eq("f_stall_off", stall_if, 1'b0);
        if_req = 1'b0;
        cyc(1);
        check_eq("f_ack_pulse", if_ack, 1'b0);
        check_eq("f_rdata_hold", if_rdata, 16'hA5A5);

        // Simultaneous requests: data first, then fetch
        if_req = 1'b1; if_addr = 16'h0030;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
        mem_data = 16'h1234; rdy_lat = 3;
        cyc(1);
        check_eq("s_m_addr_d", m_addr, 16'h0020);
        check_eq("s_stall_mem", stall_mem, 1'b1);
        check_eq("s_stall_if", stall_if, 1'b1);
        cyc(2);
        check_eq("s_wait", {m_en, d_ack}, 2'b10);
        cyc(1);
        check_eq("s_d_ack", d_ack, 1'b1);
        check_eq("s_d_rdata", d_rdata, 16'h1234);
        check_eq("s_if_ack_lo", if_ack, 1'b0);
        check_eq("s_err", err, 1'b0);
        check_eq("s_m_en_off", m_en, 1'b0);
        d_req = 1'b0; mem_data = 16'h5678; rdy_lat = 1;
        cyc(1);
        check_eq("s_idle_gap", m_en, 1'b0);
        cyc(1);
        check_eq("s_if_grant", m_en, 1'b1);
        check_eq("s_m_addr_if", m_addr, 16'h0030);
        cyc(1);
        check_eq("s_if_ack", if_ack, 1'b1);
        check_eq("s_if_rdata", if_rdata, 16'h5678);
        if_req = 1'b0;
        cyc(1);

        // Write timeout: d_rdata must keep 0x1234
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF; rdy_lat = 0;
        cyc(1);
        check_eq("w_m_we", m_we, 1'b1);
        check_eq("w_m_addr", m_addr, 16'h0040);
        check_eq("w_m_wdata", m_wdata, 16'hBEEF);
        cyc(3);
        check_eq("w_busy4", {m_en, d_ack}, 2'b10);
        cyc(1);
        check_eq("w_to_ack", {d_ack, err}, 2'b11);
        check_eq("w_rdata_keep", d_rdata, 16'h1234);
        d_req = 1'b0;
        cyc(1);
        check_eq("w_err_pulse", {d_ack, err}, 2'b00);

        // Read timeout returns all ones
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0050; rdy_lat = 0;
        cyc(5);
        check_eq("r_to_ack", {d_ack, err}, 2'b11);
        check_eq("r_to_rdata", d_rdata, 16'hFFFF);
        d_req = 1'b0;
        cyc(1);

        // Ready arriving in the timeout cycle counts as success
        d_req = 1'b1; d_addr = 16'h0052; mem_data = 16'hC3C3; rdy_lat = 4;
        cyc(5);
        check_eq("tie_ack", {d_ack, err}, 2'b10);
        check_eq("tie_rdata", d_rdata, 16'hC3C3);
        d_req = 1'b0;
        cyc(1);

        // Reset during a fetch abandons it
        if_req = 1'b1; if_addr = 16'h0060; rdy_lat = 0;
        cyc(1);
        check_eq("rb_m_en", m_en, 1'b1);
        reset = 1'b1; if_req = 1'b0;
        #1 check_eq("rb_m_en_clr", m_en, 1'b0);
        cyc(1);
        reset = 1'b0;
        seen_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            if (if_ack) seen_ack = 1'b1;
        end
        check_eq("rb_no_ack", seen_ack, 1'b0);
        check_eq("rb_rdata_clr", if_rdata, 16'h0000);
        if_req = 1'b1; if_addr = 16'h0070; mem_data = 16'h0F0F; rdy_lat = 1;
        cyc(2);
        check_eq("rb_next_ack", {if_ack, err}, 2'b10);
        check_eq("rb_next_rdata", if_rdata, 16'h0F0F);
        if_req = 1'b0;
        cyc(1);

        // Grant order with both requests held
`ifdef MEM_ARBITER_STARVE_GUARD_EN
        exp_order = '{0, 0, 0, 1, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0080;
        if_req = 1'b1; if_addr = 16'h0090; rdy_lat = 1;
        n_grants = 0; prev_en = 1'b0;
        for (int i = 0; i < 40 && n_grants < 5; i++) begin
            cyc(1);
            if (m_en && !prev_en) begin
                got_order[n_grants] = (m_addr == 16'h0090) ? 1 : 0;
                n_grants++;
            end
            prev_en = m_en;
        end
        d_req = 1'b0; if_req = 1'b0;
        check_eq("sv_count", n_grants, 5);
        for (int i = 0; i < n_grants; i++)
            check_eq($sformatf("sv_order%0d", i), got_order[i], exp_order[i]);
        cyc(4);

        check_eq("ack_excl", ack_both, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: AW, 16, address width of all address ports.
REQ-002 Parameter: DW, 16, data width of all data ports.
REQ-003 Parameter: MAX_WAIT, 15, busy cycles without m_ready before timeout abort (range 1..255).
REQ-004 Parameter: STARVE_LIM, 3, consecutive data grants with fetch pending before fetch is forced (used only under REQ-027).
REQ-005 The block SHALL use a single clock and an asynchronous, active-high reset, with ports named as follows:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request, held until if_ack.
- if_addr  in  AW  fetch address.
- if_rdata  out  DW  fetch read data, valid with if_ack.
- if_ack  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request, held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_rdata  out  DW  data read data, valid with d_ack.
- d_ack  out  1  one-cycle data completion pulse.
- err  out  1  qualifies the ack pulse: 1 = timeout abort.
- stall_if  out  1  freeze PC and IF_ID.
- stall_mem  out  1  freeze pipeline at EX_MEM and upstream.
- m_en  out  1  memory access enable.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data.
- m_ready  in  1  memory completion, sampled while m_en = 1.

Function
REQ-006 The block SHALL arbitrate one single-ported unified memory between the fetch port and the data port.
REQ-007 FSM states SHALL be IDLE, IF_BUSY and D_BUSY.
REQ-008 IDLE transitions: d_req -> D_BUSY; else if_req -> IF_BUSY; else stay. Data has priority by default.
REQ-009 On entry to a BUSY state, m_en, m_we, m_addr and m_wdata SHALL be registered from the granted port and held constant until exit.
- For fetch grants, m_we = 0.
- m_en rises in the cycle after the request is sampled.
REQ-010 In a BUSY state, m_ready = 1 SHALL capture m_rdata into the granted port's rdata register.
- The granted ack pulses in the next cycle with err = 0.
- The FSM returns to IDLE and m_en deasserts.
REQ-011 The minimum latency from request sampled to ack SHALL be 2 cycles when m_ready is returned in the first m_en cycle.
REQ-012 A wait counter SHALL increment each BUSY cycle without m_ready. When it reaches MAX_WAIT:
- Return to IDLE.
- Pulse the granted ack with err = 1.
- Set rdata to all ones.
REQ-013 The wait counter SHALL clear on every BUSY entry and SHALL saturate, never wrap.
REQ-014 The FSM SHALL spend at least one IDLE cycle between transactions; back-to-back grants are not issued.
REQ-015 Stall outputs SHALL be combinational:
- stall_if = if_req & ~if_ack.
- stall_mem = d_req & ~d_ack.
REQ-016 A request dropped while its transaction is BUSY SHALL NOT abort the transaction; the resulting ack is still pulsed and is ignored by the requester.
REQ-017 Simultaneous m_ready and timeout in the same cycle SHALL resolve as success.
REQ-018 rdata registers SHALL hold their value between acks; writes SHALL leave d_rdata unchanged.
REQ-019 if_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-020 Reset SHALL force the following, regardless of FSM state:
- FSM to IDLE.
- m_en = m_we = 0.
- m_addr = m_wdata = 0.
- if_ack = d_ack = err = 0.
- if_rdata = d_rdata = 0.
- Wait and starve counters to 0.
REQ-021 Reset asserted mid-transaction SHALL abandon it with no ack after release.
REQ-022 The first grant SHALL occur no earlier than the first rising edge after reset deasserts.

Configuration
REQ-027 Macro MEM_ARBITER_STARVE_GUARD_EN controls fetch-starvation protection.
- When defined: count consecutive data grants made while if_req = 1. When the count reaches STARVE_LIM, the next IDLE grant goes to fetch even if d_req = 1. The count clears on any fetch grant.
- When undefined: strict data priority, with no counter logic.

Verification
REQ-030 Fetch only: if_req = 1, if_addr = 0x0010, m_ready returned 1st cycle with m_rdata = 0xA5A5 -> m_en 1 cycle, if_ack 2 cycles after the request with if_rdata = 0xA5A5 and err = 0; stall_if high for 2 cycles.
REQ-031 Simultaneous requests: if_req and d_req (read 0x0020), m_ready after 3 cycles -> data granted first, d_ack, one IDLE cycle, then fetch granted.
REQ-032 Timeout with MAX_WAIT = 4: d_req write to 0x0040, m_ready held 0 -> d_ack with err = 1 after 4 busy cycles, d_rdata unchanged.
REQ-033 Reset in IF_BUSY: reset asserted 1 cycle into a fetch -> m_en = 0 immediately, no if_ack ever, next request completes normally.
REQ-034 Starve guard: macro defined, STARVE_LIM = 3, d_req and if_req held continuously -> grant order D, D, D, IF, D; without the macro -> D only until d_req drops.
